// File: rtl/video_pkg.sv
// video_pkg: shared pixel/address widths and line-fetch FSM states.
package video_pkg;
  localparam int PIX_W  = 16;
  localparam int ADDR_W = 24;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_WAIT_LINE} fetch_state_e;
endpackage

// File: rtl/line_buf_dpram.sv
// line_buf_dpram: simple dual-port line RAM, one write port, registered read port.
module line_buf_dpram
  import video_pkg::*;
#(
  parameter int DEPTH = 2560,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [PIX_W-1:0] rdata_o
);
  logic [PIX_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/video_line_fetch.sv
// video_line_fetch: ping-pong line fetcher from frame buffer bursts to a pixel stream.
// Optional VIDEO_LINE_FETCH_UFCNT_EN adds uf_count, a saturating underflow-line counter.
module video_line_fetch
  import video_pkg::*;
#(
  parameter int                H_DISP    = 1280,
  parameter int                V_DISP    = 720,
  parameter int                BURST_LEN = 64,
  parameter logic [ADDR_W-1:0] FB_BASE   = 24'h000000
) (
  input  logic              pixel_clk,
  input  logic              sys_rst,
  input  logic              video_vs,
  input  logic              data_req,
  output logic [PIX_W-1:0]  pixel_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              underflow
`ifdef VIDEO_LINE_FETCH_UFCNT_EN
  ,
  output logic [15:0]       uf_count
`endif
);
  localparam int AW = $clog2(2 * H_DISP);
  localparam int IW = $clog2(H_DISP + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int LW = $clog2(V_DISP + 1);
  fetch_state_e      state_q, state_d;
  logic              fb_q, fb_d, abort_q, abort_d;
  logic [1:0]        rdy_q, rdy_d, rdy_clr;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [IW-1:0]     widx_q, widx_d, pidx_q, pidx_d;
  logic [LW-1:0]     line_q, line_d;
  logic              vs_q, drq_q, disp_q, ok_q, uf_q;
  logic              vs_fall, dr_rise, dr_fall, fb_n, free, wr_en, rd_bank, swap, restart;
  logic [AW-1:0]     waddr, raddr;
  logic [PIX_W-1:0]  ram_rd;
  assign vs_fall = vs_q & ~video_vs;
  assign dr_rise = data_req & ~drq_q;
  assign dr_fall = ~data_req & drq_q;
  assign fb_n    = ~fb_q;
  // A displayed bank is released when its line ends; an unready bank is free already.
  assign rdy_clr = (dr_fall && ok_q) ? (2'b01 << disp_q) : 2'b00;
  assign free    = ~rdy_q[fb_n] | rdy_clr[fb_n];
  assign wr_en   = (state_q == S_DATA) && rd_valid && !abort_q && !vs_fall;
  assign rd_bank = dr_rise ? fb_n : disp_q;
  assign waddr   = (fb_q ? AW'(H_DISP) : AW'(0)) + AW'(widx_q);
  assign raddr   = (rd_bank ? AW'(H_DISP) : AW'(0)) + AW'(pidx_q);
  assign pidx_d  = !data_req ? '0 : (pidx_q == IW'(H_DISP - 1)) ? pidx_q : pidx_q + 1'b1;
  assign rd_req     = (state_q == S_REQ);
  assign rd_addr    = addr_q;
  assign underflow  = uf_q;
  assign pixel_data = (drq_q && ok_q) ? ram_rd : '0;
  always_comb begin
    state_d = state_q;
    fb_d    = fb_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    widx_d  = widx_q;
    line_d  = line_q;
    rdy_d   = rdy_q & ~rdy_clr;
    abort_d = abort_q | (vs_fall & (state_q == S_REQ || state_q == S_DATA));
    swap    = 1'b0;
    restart = vs_fall & (state_q == S_IDLE || state_q == S_WAIT_LINE);
    case (state_q)
      S_REQ: if (rd_ack) begin
        state_d = S_DATA;
        beat_d  = '0;
      end
      S_DATA: if (rd_valid) begin
        beat_d = beat_q + 1'b1;
        widx_d = wr_en ? widx_q + 1'b1 : widx_q;
        if (beat_q == BW'(BURST_LEN - 1)) begin
          if (abort_q || vs_fall) restart = 1'b1;
          else begin
            addr_d = addr_q + ADDR_W'(BURST_LEN);
            if (widx_q != IW'(H_DISP - 1)) state_d = S_REQ;
            else begin
              rdy_d[fb_q] = 1'b1;
              widx_d      = '0;
              swap        = free;
              state_d     = S_WAIT_LINE;
            end
          end
        end
      end
      S_WAIT_LINE: swap = free;
      default: ;
    endcase
    if (swap) begin
      fb_d    = fb_n;
      line_d  = line_q + 1'b1;
      state_d = (line_q == LW'(V_DISP - 1)) ? S_IDLE : S_REQ;
    end
    if (restart) begin
      state_d = S_REQ;
      addr_d  = FB_BASE;
      fb_d    = 1'b0;
      line_d  = '0;
      widx_d  = '0;
      abort_d = 1'b0;
      rdy_d   = '0;
    end
  end
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      fb_q    <= 1'b0;
      addr_q  <= FB_BASE;
      beat_q  <= '0;
      widx_q  <= '0;
      line_q  <= '0;
      rdy_q   <= '0;
      abort_q <= 1'b0;
      vs_q    <= 1'b1;
      drq_q   <= 1'b0;
      disp_q  <= 1'b0;
      ok_q    <= 1'b0;
      pidx_q  <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fb_q    <= fb_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      widx_q  <= widx_d;
      line_q  <= line_d;
      rdy_q   <= rdy_d;
      abort_q <= abort_d;
      vs_q    <= video_vs;
      drq_q   <= data_req;
      pidx_q  <= pidx_d;
      if (dr_rise) begin
        disp_q <= fb_n;
        ok_q   <= rdy_q[fb_n];
        if (!rdy_q[fb_n]) uf_q <= 1'b1;
      end
    end
  end
`ifdef VIDEO_LINE_FETCH_UFCNT_EN
  logic [15:0] uf_cnt_q;
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) uf_cnt_q <= '0;
    else if (dr_rise && !rdy_q[fb_n] && uf_cnt_q != 16'hFFFF) uf_cnt_q <= uf_cnt_q + 16'd1;
  end
  assign uf_count = uf_cnt_q;
`endif
  line_buf_dpram #(.DEPTH(2 * H_DISP), .AW(AW)) u_ram (
    .clk_i  (pixel_clk),
    .we_i   (wr_en),
    .waddr_i(waddr),
    .wdata_i(rd_data),
    .raddr_i(raddr),
    .rdata_o(ram_rd)
  );
endmodule

// File: tb/tb_video_line_fetch.sv
// tb_video_line_fetch: scoreboard bench with a burst memory model for video_line_fetch.
module tb_video_line_fetch;
  localparam int H = 1280, V = 4, BL = 64;
  localparam logic [23:0] FB = 24'h100000;
  logic pixel_clk = 1'b0;
  logic sys_rst = 1'b1, video_vs = 1'b1, data_req = 1'b0, rd_ack = 1'b0, rd_valid = 1'b0;
  logic [15:0] rd_data = '0, pixel_data;
  logic rd_req, underflow;
  logic [23:0] rd_addr, mem_a;
`ifdef VIDEO_LINE_FETCH_UFCNT_EN
  logic [15:0] uf_count;
`endif
  int vectors = 0, miscompares = 0;
  int ack_delay = 0, burst_cnt = 0, beat_done = 0;
  bit mem_stall = 0, mem_busy = 0, drq_prev = 0;
  logic [15:0] sb[$];
  logic [23:0] burst_addr[$];

  video_line_fetch #(.H_DISP(H), .V_DISP(V), .BURST_LEN(BL), .FB_BASE(FB)) dut (
    .pixel_clk (pixel_clk),
    .sys_rst   (sys_rst),
    .video_vs  (video_vs),
    .data_req  (data_req),
    .pixel_data(pixel_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .underflow (underflow)
`ifdef VIDEO_LINE_FETCH_UFCNT_EN
    ,
    .uf_count  (uf_count)
`endif
  );

  always #5 pixel_clk = ~pixel_clk;

  // Memory returns word address low bits as data, so line n pixel i reads back n*H+i.
  initial begin : mem_model
    forever begin
      @(negedge pixel_clk);
      if (!sys_rst && rd_req && !mem_stall) begin
        mem_busy = 1'b1;
        repeat (ack_delay) @(negedge pixel_clk);
        mem_a = rd_addr;
        rd_ack = 1'b1;
        burst_addr.push_back(mem_a);
        burst_cnt++;
        beat_done = 0;
        @(negedge pixel_clk);
        rd_ack = 1'b0;
        for (int k = 0; k < BL && !sys_rst; k++) begin
          rd_valid = 1'b1;
          rd_data = 16'(mem_a + 24'(k));
          @(negedge pixel_clk);
          beat_done = k + 1;
        end
        rd_valid = 1'b0;
        mem_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_fetched(input int n);
    for (int t = 0; t < 10000 && !(burst_cnt >= n && !mem_busy); t++) @(posedge pixel_clk);
    vectors++;
    if (!(burst_cnt >= n && !mem_busy)) begin
      miscompares++;
      $display("FAIL fetch_wait: bursts %0d, required >= %0d", burst_cnt, n);
    end
    repeat (3) @(negedge pixel_clk);
  endtask

  task automatic show_line(input int line, input bit ok);
    logic [15:0] exp;
    for (int c = 0; c <= H; c++) begin
      @(negedge pixel_clk);
      vectors++;
      if (drq_prev) begin
        exp = sb.pop_front();
        if (pixel_data !== exp) begin
          miscompares++;
          $display("FAIL pixel line %0d idx %0d: got %h want %h", line, c - 1, pixel_data, exp);
        end
      end else if (pixel_data !== 16'h0000) begin
        miscompares++;
        $display("FAIL pixel_idle line %0d: got %h want 0000", line, pixel_data);
      end
      data_req = (c < H);
      if (data_req) sb.push_back(ok ? 16'(FB + 24'(line * H + c)) : 16'h0000);
      drq_prev = data_req;
    end
    repeat (8) @(negedge pixel_clk);
  endtask

  task automatic test_reset;
    int hi = 0;
    sys_rst = 1'b1;
    repeat (4) @(negedge pixel_clk);
    sys_rst = 1'b0;
    @(negedge pixel_clk);
    vectors += 4;
    if (rd_req !== 1'b0) begin miscompares++; $display("FAIL reset_rd_req: got %b want 0", rd_req); end
    if (rd_addr !== FB) begin miscompares++; $display("FAIL reset_rd_addr: got %h want %h", rd_addr, FB); end
    if (pixel_data !== 16'h0) begin miscompares++; $display("FAIL reset_pixel: got %h want 0000", pixel_data); end
    if (underflow !== 1'b0) begin miscompares++; $display("FAIL reset_underflow: got %b want 0", underflow); end
    repeat (10) begin @(negedge pixel_clk); if (rd_req) hi++; end
    vectors++;
    if (hi != 0) begin miscompares++; $display("FAIL reset_idle: rd_req high %0d cycles, want 0", hi); end
  endtask

  task automatic test_first_request;
    int base = burst_cnt;
    ack_delay = 5;
    @(negedge pixel_clk);
    video_vs = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pixel_clk);
      video_vs = 1'b1;
      vectors++;
      if (rd_req !== 1'b1 || rd_addr !== FB) begin
        miscompares++;
        $display("FAIL req_hold cycle %0d: rd_req %b addr %h, want 1 %h", i, rd_req, rd_addr, FB);
      end
    end
    wait_fetched(base + 2);
    vectors += 2;
    if (burst_addr[base] !== FB) begin
      miscompares++; $display("FAIL first_addr: got %h want %h", burst_addr[base], FB);
    end
    if (burst_addr[base + 1] !== FB + 24'd64) begin
      miscompares++; $display("FAIL second_addr: got %h want %h", burst_addr[base + 1], FB + 24'd64);
    end
  endtask

  task automatic test_frame(input int start);
    for (int k = 0; k < V; k++) begin
      wait_fetched(start + 20 * (k + 1));
      show_line(k, 1'b1);
    end
    repeat (50) @(negedge pixel_clk);
    vectors += 3;
    if (burst_cnt - start != V * 20) begin
      miscompares++; $display("FAIL frame_bursts: got %0d want %0d", burst_cnt - start, V * 20);
    end
    if (rd_req !== 1'b0) begin miscompares++; $display("FAIL frame_idle: rd_req %b want 0", rd_req); end
    if (underflow !== 1'b0) begin miscompares++; $display("FAIL frame_underflow: got %b want 0", underflow); end
    for (int i = 0; i < V * 20; i++) begin
      vectors++;
      if (burst_addr[start + i] !== FB + 24'(64 * i)) begin
        miscompares++;
        $display("FAIL burst_addr %0d: got %h want %h", i, burst_addr[start + i], FB + 24'(64 * i));
      end
    end
  endtask

  task automatic test_underflow;
    int base = burst_cnt;
    ack_delay = 0;
    @(negedge pixel_clk);
    video_vs = 1'b0;
    @(negedge pixel_clk);
    video_vs = 1'b1;
    for (int t = 0; t < 10000 && burst_cnt < base + 25; t++) @(posedge pixel_clk);
    mem_stall = 1'b1;
    vectors++;
    if (burst_cnt < base + 25) begin miscompares++; $display("FAIL uf_wait: bursts %0d want %0d", burst_cnt - base, 25); end
    show_line(0, 1'b1);
    vectors++;
    if (underflow !== 1'b0) begin miscompares++; $display("FAIL uf_early: got %b want 0", underflow); end
    show_line(1, 1'b0);
    vectors++;
    if (underflow !== 1'b1) begin miscompares++; $display("FAIL uf_flag: got %b want 1", underflow); end
`ifdef VIDEO_LINE_FETCH_UFCNT_EN
    vectors++;
    if (uf_count !== 16'd1) begin miscompares++; $display("FAIL uf_count: got %0d want 1", uf_count); end
`endif
    mem_stall = 1'b0;
  endtask

  task automatic test_vs_abort;
    int idx, bad = 0;
    for (int t = 0; t < 10000 && !(mem_busy && beat_done == 9); t++) @(posedge pixel_clk);
    @(negedge pixel_clk);
    video_vs = 1'b0;
    idx = burst_cnt;
    for (int t = 0; t < BL; t++) begin
      @(negedge pixel_clk);
      #2;
      video_vs = 1'b1;
      if (rd_valid && rd_req) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL drain_overlap: %0d cycles, want 0", bad); end
    wait_fetched(idx + 1);
    vectors++;
    if (burst_addr[idx] !== FB) begin miscompares++; $display("FAIL abort_addr: got %h want %h", burst_addr[idx], FB); end
    wait_fetched(idx + 20);
    show_line(0, 1'b1);
    vectors++;
    if (underflow !== 1'b1) begin miscompares++; $display("FAIL uf_sticky: got %b want 1", underflow); end
  endtask

  task automatic test_reset_mid_data;
    int hi = 0;
    for (int t = 0; t < 10000 && !(mem_busy && beat_done == 5); t++) @(posedge pixel_clk);
    @(negedge pixel_clk);
    sys_rst = 1'b1;
    repeat (3) @(negedge pixel_clk);
    sys_rst = 1'b0;
    @(negedge pixel_clk);
    vectors += 4;
    if (rd_req !== 1'b0) begin miscompares++; $display("FAIL mid_rst_rd_req: got %b want 0", rd_req); end
    if (pixel_data !== 16'h0) begin miscompares++; $display("FAIL mid_rst_pixel: got %h want 0000", pixel_data); end
    if (underflow !== 1'b0) begin miscompares++; $display("FAIL mid_rst_underflow: got %b want 0", underflow); end
    if (rd_addr !== FB) begin miscompares++; $display("FAIL mid_rst_addr: got %h want %h", rd_addr, FB); end
    repeat (20) begin @(negedge pixel_clk); if (rd_req) hi++; end
    vectors++;
    if (hi != 0) begin miscompares++; $display("FAIL mid_rst_idle: rd_req high %0d cycles, want 0", hi); end
  endtask

  initial begin
    test_reset();
    test_first_request();
    test_frame(0);
    test_underflow();
    test_vs_abort();
    test_reset_mid_data();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/video_line_fetch.md
VIDEO_LINE_FETCH -- requirements
Module: video_line_fetch

Interface
REQ-001 SHALL have parameter H_DISP, default 1280, active pixels per line.
REQ-002 SHALL have parameter V_DISP, default 720, active lines per frame.
REQ-003 SHALL have parameter BURST_LEN, default 64, beats per memory read burst; H_DISP is a multiple of BURST_LEN.
REQ-004 SHALL have parameter FB_BASE, default 24'h000000, frame buffer base word address.
REQ-005 SHALL have ports, one clock and synchronous active-high reset:
- pixel_clk  in  1  sole clock.
- sys_rst  in  1  synchronous reset, active-high.
- video_vs  in  1  timing-generator field sync, active low.
- data_req  in  1  pixel request, high one cycle before each active pixel.
- pixel_data  out  16  RGB565 pixel for the driver.
- rd_req  out  1  memory burst request.
- rd_addr  out  24  burst start word address.
- rd_ack  in  1  one-cycle burst acceptance.
- rd_valid  in  1  read beat valid.
- rd_data  in  16  read beat data.
- underflow  out  1  sticky line-not-ready flag.

Function
REQ-006 SHALL hold two line banks (ping-pong), each H_DISP x 16 bits.
REQ-007 SHALL run FSM IDLE -> REQ -> DATA -> (REQ | WAIT_LINE) -> REQ ... -> IDLE.
REQ-008 SHALL, on video_vs falling edge, clear line count, set fetch address to FB_BASE, select fill bank 0 and enter REQ.
REQ-009 SHALL, in REQ, hold rd_req high with stable rd_addr until the cycle rd_ack is sampled high, then go to DATA.
REQ-010 SHALL, in DATA, write each rd_valid beat to the fill bank at an incrementing index and leave after exactly BURST_LEN beats.
REQ-011 SHALL, after a burst, advance rd_addr by BURST_LEN; return to REQ while the line is incomplete, else mark the bank ready and enter WAIT_LINE.
REQ-012 SHALL, in WAIT_LINE, wait for the display bank to free (data_req falling edge), swap banks, and fetch the next line; after V_DISP lines go to IDLE.
REQ-013 SHALL, while data_req is high, read the display bank at an index counting 0..H_DISP-1; pixel_data registered, valid one cycle after data_req.
REQ-014 SHALL set underflow and output pixel_data 16'h0000 for the whole line if data_req rises while the display bank is not ready.
REQ-015 SHALL output pixel_data 16'h0000 whenever data_req was low the previous cycle.
REQ-016 SHALL ignore rd_valid outside DATA and rd_ack outside REQ.
REQ-017 SHALL, on video_vs falling edge during DATA, drain and discard the remaining beats of the current burst, then restart per REQ-008; during REQ it SHALL finish the handshake, then drain.
REQ-018 SHALL handle simultaneous bank-free and fill-complete in one cycle by swapping immediately with no lost cycle.

Reset
REQ-019 SHALL, on sys_rst, enter IDLE with rd_req=0, rd_addr=FB_BASE, pixel_data=0, underflow=0, both banks not ready.
REQ-020 SHALL, on sys_rst mid-burst, abandon the burst without draining; the memory side is reset by the same reset.
REQ-021 SHALL not reset bank RAM contents.

Configuration
REQ-022 SHALL, with VIDEO_LINE_FETCH_UFCNT_EN defined, add output uf_count[15:0], a saturating count of underflow lines cleared only by reset.
REQ-023 SHALL, without VIDEO_LINE_FETCH_UFCNT_EN, have no uf_count port and no counter logic.

Structure
REQ-024 SHALL keep the FSM state enum, pixel width (16) and address width (24) in shared package video_pkg.
REQ-025 SHALL instantiate one sub-module line_buf_dpram: a simple dual-port RAM of 2*H_DISP x 16 with a registered read.

Verification
REQ-026 Reset held 3 cycles mid-DATA -> rd_req=0, pixel_data=0, underflow=0 the cycle after release.
REQ-027 video_vs falls; rd_ack after 5 cycles -> rd_addr=FB_BASE stable for 5 cycles; second request at FB_BASE+64 after 64 beats.
REQ-028 Line 0 preloaded with 0..1279; data_req high 1280 cycles -> pixel_data=0..1279 in order, one cycle behind data_req.
REQ-029 Memory stalled so line 1 is incomplete at data_req rise -> underflow=1, pixel_data=0 all line; uf_count=1 with the macro defined.
REQ-030 video_vs falls after beat 10 of a burst -> 54 beats discarded, next rd_addr=FB_BASE, no bank corruption.
REQ-031 Full 720-line frame -> exactly 720*20 bursts issued, FSM in IDLE before the next video_vs falling edge.
